async_sink: RTL

- Receiving end of the four-phase, return-to-zero dual-rail channel our async sources drive.
- Detects completion of a dual-rail token and brings it into the clocked domain through a synchronizer.
- Converts the token back to single-rail and presents it on a valid/ready interface.
- Drives the ack rail that lets the source return to the spacer (all-zero) state.
- Sits at the boundary between the async CORDIC datapath and the synchronous result consumer.

---
 rtl/pa_AsyncCordic.sv | 21 ++
 rtl/async_sync_bit.sv | 30 +++
 rtl/async_sink.sv | 115 +++++++++++
 3 files changed

// File: rtl/pa_AsyncCordic.sv
// ============================================================================
// pa_AsyncCordic : shared types for the async CORDIC datapath and its sink
// Revision: 1.0
// ============================================================================
`default_nettype none

package pa_AsyncCordic;

  typedef struct packed {
    logic data_1;
    logic data_0;
  } dual_rail_t;

  typedef enum logic [0:0] {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } sink_state_e;

endpackage

`default_nettype wire

// File: rtl/async_sync_bit.sv
// ============================================================================
// async_sync_bit : SYNC_STAGES-deep single-bit synchronizer, sync active-low rst
// Revision: 1.0
// ============================================================================
`default_nettype none

module async_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/async_sink.sv
// ============================================================================
// async_sink : four-phase dual-rail receiver presenting tokens on valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module async_sink
  import pa_AsyncCordic::*;
#(
  parameter int SIZE        = 31,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  dual_rail_t [SIZE:0]     data_i,
  output logic                    ack_o,
  output logic [SIZE:0]           data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    err_o
);

  logic [SIZE:0] w_rail_any;
  logic [SIZE:0] w_rail_both;
  logic [SIZE:0] w_token;
  logic          w_full;
  logic          w_empty;
  logic          w_illegal;
  logic          w_full_s;
  logic          w_empty_s;
  logic          w_capture;
  sink_state_e   w_state_nxt;

  sink_state_e   r_state;
  logic [SIZE:0] r_data;
  logic          r_valid;
  logic          r_err;

  always_comb begin
    w_rail_any  = '0;
    w_rail_both = '0;
    w_token     = '0;
    for (int i = 0; i <= SIZE; i++) begin
      w_rail_any[i]  = data_i[i].data_1 | data_i[i].data_0;
      w_rail_both[i] = data_i[i].data_1 & data_i[i].data_0;
      w_token[i]     = data_i[i].data_1;
    end
  end

  assign w_full    = &w_rail_any;
  assign w_empty   = ~|w_rail_any;
  assign w_illegal = |w_rail_both;

  // Only the completion flags cross domains; raw rails are held stable by the
  // source until ack rises, so they are sampled directly at capture.
  async_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_full (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (w_full),
    .o_q    (w_full_s)
  );

  async_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_empty (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (w_empty),
    .o_q    (w_empty_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        // Holding off capture keeps ack low, which stalls the source.
        if (w_full_s && (!r_valid || ready_i)) begin
          w_capture   = 1'b1;
          w_state_nxt = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (w_empty_s) begin
          w_state_nxt = WAIT_DATA;
        end
      end
      default: w_state_nxt = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= WAIT_DATA;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_data  <= w_token;
        r_valid <= 1'b1;
        r_err   <= r_err | w_illegal;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ack_o   = (r_state == WAIT_NULL);
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign err_o   = r_err;

endmodule

`default_nettype wire
